// File: rtl/led_breathe.sv
// led_breathe: LED "breathing" controller.
// A WIDTH-bit free-running PWM counter compares against a duty register
// (LEVEL) that ramps up and down in STEP increments, once per TICK strobe,
// with an optional dwell of HOLD ticks at the peak and at the trough.
//
// Ports:
//   CLK    in   single clock, same domain as the upstream tick source
//   RESETN in   asynchronous active-low reset
//   TICK   in   one-cycle strobe advancing the ramp (level-sampled each edge)
//   EN     in   level enable; low forces OFF and clears all progress
//   LED    out  registered PWM drive, one cycle behind the compare
//   LEVEL  out  current duty value
//   STATE  out  encoded FSM state
//
// state   | meaning
// --------+-----------------------------------------------
// OFF     | disabled; LEVEL=0, waiting for EN
// RISE    | LEVEL += STEP per tick, saturating at max
// HOLD_HI | dwell at max for HOLD ticks
// FALL    | LEVEL -= STEP per tick, clamping at 0
// HOLD_LO | dwell at 0 for HOLD ticks

module led_breathe #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int HOLD  = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             TICK,
    input  logic             EN,
    output logic             LED,
    output logic [WIDTH-1:0] LEVEL,
    output logic [2:0]       STATE
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]   HOLD_LAST = (HOLD > 0) ? HCW'(HOLD - 1) : '0;
    localparam logic [WIDTH-1:0] LEVEL_MAX = '1;
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);

    state_t           state;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] pwm_cnt;
    logic [HCW-1:0]   hold_cnt;

    // Ramp arithmetic is done one bit wider so saturation/clamping never wraps.
    logic [WIDTH:0] rise_sum;
    logic           rise_sat;
    logic           fall_zero;

    always_comb begin
        rise_sum  = {1'b0, level_q} + STEP_W;
        rise_sat  = (rise_sum >= {1'b0, LEVEL_MAX});
        fall_zero = ({1'b0, level_q} <= STEP_W);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pwm_cnt <= '0;
        end else if (!EN) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // LED compares against the pre-edge LEVEL, so a ramp step shows up on
    // the pin one cycle after LEVEL changes.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            LED <= 1'b0;
        end else begin
            LED <= (pwm_cnt < level_q);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= S_OFF;
            level_q  <= '0;
            hold_cnt <= '0;
        end else if (!EN) begin
            // Enable has priority over a coincident tick; no resume on re-enable.
            state    <= S_OFF;
            level_q  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    state    <= S_RISE;
                    level_q  <= '0;
                    hold_cnt <= '0;
                end
                S_RISE: begin
                    if (TICK) begin
                        if (rise_sat) begin
                            level_q <= LEVEL_MAX;
                            state   <= (HOLD > 0) ? S_HOLD_HI : S_FALL;
                        end else begin
                            level_q <= rise_sum[WIDTH-1:0];
                        end
                    end
                end
                S_HOLD_HI: begin
                    if (TICK) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= S_FALL;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                S_FALL: begin
                    if (TICK) begin
                        if (fall_zero) begin
                            level_q <= '0;
                            state   <= (HOLD > 0) ? S_HOLD_LO : S_RISE;
                        end else begin
                            level_q <= level_q - STEP_W[WIDTH-1:0];
                        end
                    end
                end
                S_HOLD_LO: begin
                    if (TICK) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= S_RISE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_OFF;
                    level_q  <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign LEVEL = level_q;
    assign STATE = state;

endmodule

// File: doc/led_breathe.md
LED_BREATHE -- requirements
Module: led_breathe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the PWM counter and the duty register.
REQ-002 Parameter STEP, default 1: duty increment/decrement applied per TICK; legal range 1..2^WIDTH-1.
REQ-003 Parameter HOLD, default 4: number of TICKs to dwell at peak and at trough; 0 means no dwell.
REQ-004 CLK  input  1: single clock; the same domain as the upstream counter.
REQ-005 RESETN  input  1: reset, asynchronous and active-low.
REQ-006 TICK  input  1: one-cycle strobe from the upstream counter's COUT that advances the brightness ramp.
REQ-007 EN  input  1: level enable; low forces the block to OFF.
REQ-008 LED  output  1: PWM drive for the LED pin; registered.
REQ-009 LEVEL  output  WIDTH: current duty value.
REQ-010 STATE  output  3: encoded FSM state (OFF=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4).

Function
REQ-011 The PWM counter shall be WIDTH bits, shall increment by 1 every CLK while EN=1, shall wrap 2^WIDTH-1 -> 0, and shall be held at 0 while EN=0.
REQ-012 LED shall be registered from (pwm_cnt < LEVEL) with one CLK latency: LEVEL=0 gives a constant 0, and LEVEL=2^WIDTH-1 gives a high time of 2^WIDTH-1 out of 2^WIDTH cycles.
REQ-013 OFF: LEVEL=0, LED=0, hold counter=0; when EN=1 in OFF, the next state shall be RISE.
REQ-014 RISE: on each TICK, LEVEL shall become min(LEVEL+STEP, 2^WIDTH-1), computed at WIDTH+1 bits with no wrap.
REQ-015 RISE: when that update saturates LEVEL at 2^WIDTH-1, the next state shall be HOLD_HI, or FALL if HOLD=0.
REQ-016 HOLD_HI: LEVEL is unchanged; each TICK increments the hold counter.
REQ-017 HOLD_HI: the TICK on which the hold counter equals HOLD-1 shall move the FSM to FALL and clear the hold counter.
REQ-018 FALL: on each TICK, LEVEL shall become max(LEVEL-STEP, 0) with no underflow.
REQ-019 FALL: on reaching 0, the next state shall be HOLD_LO, or RISE if HOLD=0.
REQ-020 HOLD_LO: behaves like HOLD_HI, but exits to RISE.
REQ-021 TICK in the same cycle as EN=0: EN=0 shall have priority; the next state is OFF, LEVEL=0, and LED=0 one cycle later.
REQ-022 EN falling mid-ramp from any state: the block shall go to OFF on the next CLK.
REQ-023 EN re-rising: the ramp shall always restart from LEVEL=0 in RISE; there is no resume.
REQ-024 TICK shall be sampled only on a rising CLK edge; TICK held high for N cycles counts as N ticks.
REQ-025 Unused STATE encodings shall recover to OFF on the next CLK.
REQ-026 Every state transition and every LEVEL update shall take effect on the CLK edge that samples the TICK.

Reset
REQ-027 While RESETN=0, and immediately on assertion regardless of CLK: LED=0, LEVEL=0, STATE=OFF, PWM counter=0, hold counter=0.
REQ-028 After RESETN rises, with EN=1, the block shall enter RISE on the first CLK edge.
REQ-029 Reset asserted mid-operation shall discard all ramp and hold progress.

Verification (WIDTH=4, STEP=1, HOLD=2 unless stated)
REQ-030 Reset: pulse RESETN low asynchronously between edges -> LED=0, LEVEL=0, STATE=0 with no clock edge required.
REQ-031 Full cycle: EN=1 with TICK every 20 cycles.
  - RISE phase: LEVEL 0,1..15.
  - STATE then goes 2; after 2 ticks it goes 3.
  - FALL phase: LEVEL 15..0.
  - STATE then goes 4; after 2 ticks it goes 1.
  - One full period = 34 ticks.
REQ-032 PWM duty: hold LEVEL=5 with TICK=0 -> LED high exactly 5 of every 16 cycles, lagging pwm_cnt by 1 cycle.
REQ-033 Saturation, STEP=6: RISE gives LEVEL 6, 12, 15 then HOLD_HI; FALL gives 9, 3, 0 then HOLD_LO.
REQ-034 EN drop: EN=0 coincident with a TICK while LEVEL=9 in FALL -> next cycle STATE=0 and LEVEL=0, then LED=0. EN=1 again -> LEVEL restarts at 0 in RISE.
REQ-035 HOLD=0 with STEP=15: LEVEL alternates 15, 0, 15 on successive ticks; STATE alternates 3, 1, 3 and never visits 2 or 4.
